// File: rtl/button_grid_ctl.sv
// ROWS x COLS grid of image buttons: mouse hover/click detection plus a VGA overlay drawn from a shared ROM.
// Latency: vga_in -> vga_out 2 cycles; mouse pos -> hover 1 cycle; mouse_left edge -> button_pressed 2 cycles.
// Backpressure: none; the pixel stream is free-running and every stage accepts data every cycle.
//
// Ports: clk/rst (async, active high); enable + btn_mask select live buttons; mouse_left/xpos/ypos drive
// hover and click; vga_in/vga_out is the overlay bus; pixel_address/rgb_pixel talk to the image ROM;
// button_pressed/button_index report clicks; hover_valid/hover_index report the button under the cursor.

// VGA bus layout (shared with the rest of the overlay chain):
// {hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk, rgb[11:0]}
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif
`ifndef VGA_HCOUNT_BITS
`define VGA_HCOUNT_BITS 37:27
`endif
`ifndef VGA_VCOUNT_BITS
`define VGA_VCOUNT_BITS 24:14
`endif
`ifndef VGA_RGB_BITS
`define VGA_RGB_BITS 11:0
`endif

module button_grid_ctl #(
    parameter int          X_POS            = 50,
    parameter int          Y_POS            = 50,
    parameter int          BTN_WIDTH        = 64,
    parameter int          BTN_HEIGHT       = 64,
    parameter int          GAP              = 8,
    parameter int          COLS             = 4,
    parameter int          ROWS             = 4,
    parameter int          IDX_W            = 6,
    parameter int          ROM_ADDRESS_SIZE = 16,
    parameter int          PRESS_ON_RELEASE = 1,
    parameter logic [11:0] HOVER_MASK       = 12'h333
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [ROWS*COLS-1:0]        btn_mask,
    input  logic                        mouse_left,
    input  logic [11:0]                 mouse_xpos,
    input  logic [11:0]                 mouse_ypos,
    input  logic [`VGA_BUS_SIZE-1:0]    vga_in,
    input  logic [11:0]                 rgb_pixel,
    output logic [ROM_ADDRESS_SIZE-1:0] pixel_address,
    output logic                        button_pressed,
    output logic [IDX_W-1:0]            button_index,
    output logic                        hover_valid,
    output logic [IDX_W-1:0]            hover_index,
    output logic [`VGA_BUS_SIZE-1:0]    vga_out
);

    localparam int MW = 1 << IDX_W;

    typedef struct packed {
        logic        hit;
        logic [2:0]  idx;
        logic [11:0] loc;
    } axis_hit_t;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HELD} state_t;

    // One-axis hit test: a comparator per button slot, gap pixels match nothing.
    // Slots never overlap, so at most one comparator fires.
    function automatic axis_hit_t axis_test(input logic [11:0] v, input int pos,
                                            input int size, input int n);
        axis_hit_t   r;
        logic [31:0] v32;
        logic [31:0] start;
        r   = '0;
        v32 = {20'b0, v};
        for (int i = 0; i < 8; i++) begin
            start = 32'(pos + i * (size + GAP));
            if (i < n && v32 >= start && v32 < start + 32'(size)) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
                r.loc = 12'(v32 - start);
            end
        end
        return r;
    endfunction

    // Out-of-range indices read as masked off.
    logic [MW-1:0] mask_ext;
    assign mask_ext = MW'(btn_mask);

    // ---------------- mouse path ----------------
    logic [3:0]       m_xsel, m_ysel;   // {hit, idx}
    logic [IDX_W-1:0] m_idx;
    logic             m_live;

    assign m_xsel = 4'(axis_test(mouse_xpos, X_POS, BTN_WIDTH, COLS) >> 12);
    assign m_ysel = 4'(axis_test(mouse_ypos, Y_POS, BTN_HEIGHT, ROWS) >> 12);
    assign m_idx  = IDX_W'(32'(m_ysel[2:0]) * 32'(COLS) + 32'(m_xsel[2:0]));
    assign m_live = enable & m_xsel[3] & m_ysel[3] & mask_ext[m_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hover_valid <= 1'b0;
            hover_index <= '0;
        end else begin
            hover_valid <= m_live;
            hover_index <= m_live ? m_idx : '0;
        end
    end

    // Edge detection on the registered button level; a press already held when
    // the grid becomes live produces no rising edge and is therefore ignored.
    logic ml_q, ml_q2;
    logic press, release_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ml_q  <= 1'b0;
            ml_q2 <= 1'b0;
        end else begin
            ml_q  <= mouse_left;
            ml_q2 <= ml_q;
        end
    end

    assign press      = ml_q & ~ml_q2;
    assign release_ev = ~ml_q & ml_q2;

    // ---------------- click FSM ----------------
    state_t           state;
    logic [IDX_W-1:0] armed_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            armed_idx      <= '0;
            button_pressed <= 1'b0;
            button_index   <= '0;
        end else begin
            button_pressed <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (press && hover_valid) begin
                        armed_idx <= hover_index;
                        if (PRESS_ON_RELEASE == 0) begin
                            button_pressed <= 1'b1;
                            button_index   <= hover_index;
                            state          <= S_HELD;
                        end else begin
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    // Losing the button beats a coincident release.
                    if (!enable || !mask_ext[armed_idx]) begin
                        state <= S_IDLE;
                    end else if (release_ev) begin
                        if (hover_valid && hover_index == armed_idx) begin
                            button_pressed <= 1'b1;
                            button_index   <= armed_idx;
                        end
                        state <= S_IDLE;
                    end
                end
                S_HELD: begin
                    if (release_ev) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- draw pipeline ----------------
    axis_hit_t                px, py;
    logic [IDX_W-1:0]         p_idx_c;
    logic [IDX_W-1:0]         p_idx;
    logic                     p_live;
    logic [`VGA_BUS_SIZE-1:0] bus_d1;

    assign px      = axis_test({1'b0, vga_in[`VGA_HCOUNT_BITS]}, X_POS, BTN_WIDTH, COLS);
    assign py      = axis_test({1'b0, vga_in[`VGA_VCOUNT_BITS]}, Y_POS, BTN_HEIGHT, ROWS);
    assign p_idx_c = IDX_W'(32'(py.idx) * 32'(COLS) + 32'(px.idx));

    // Stage 1: ROM address and per-pixel button decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_address <= '0;
            p_live        <= 1'b0;
            p_idx         <= '0;
            bus_d1        <= '0;
        end else begin
            pixel_address <= ROM_ADDRESS_SIZE'(32'(py.loc) * 32'(BTN_WIDTH) + 32'(px.loc));
            p_live        <= enable & px.hit & py.hit & mask_ext[p_idx_c];
            p_idx         <= p_idx_c;
            bus_d1        <= vga_in;
        end
    end

    // Stage 2: ROM data is back; override rgb inside live buttons only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_out <= '0;
        end else begin
            vga_out <= bus_d1;
            if (p_live) begin
                vga_out[`VGA_RGB_BITS] <= rgb_pixel ^
                    ((hover_valid && hover_index == p_idx) ? HOVER_MASK : 12'h000);
            end
        end
    end

endmodule
